// File: rtl/mem_ctrl_pkg.sv
// Shared memory-control encodings used by the instruction decoder and the
// data-memory access unit, plus the access-unit FSM state type.
package mem_ctrl_pkg;

  // MemWriteCtr {SB,SH}: selects the store width
  localparam logic [1:0] WCTR_WORD = 2'b00;
  localparam logic [1:0] WCTR_HALF = 2'b01;
  localparam logic [1:0] WCTR_BYTE = 2'b10;

  // MemOutCtr: selects the load width and sign handling
  localparam logic [2:0] OCTR_LW  = 3'b000;
  localparam logic [2:0] OCTR_LH  = 3'b001;
  localparam logic [2:0] OCTR_LB  = 3'b010;
  localparam logic [2:0] OCTR_LBU = 3'b110;
  localparam logic [2:0] OCTR_LHU = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_MERGE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dm_access_unit_if.sv
// Request/response bus between the datapath (master) and the access unit (slave).
interface dm_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_wctr;
  logic [2:0]  req_octr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_wctr, req_octr, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_wctr, req_octr, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_sram.sv
// Single-port word-wide synchronous RAM, one-cycle read latency, no reset.
module dm_sram #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];
  logic [31:0] r_rdata;

  // Write the addressed word, or register it on a read; output holds otherwise
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access unit: aligned word/half/byte loads and stores against
// dm_sram, with read-modify-write for sub-word stores.
module dm_access_unit
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic              clk,
  input logic              rst_n,
  dm_access_unit_if.slave  bus
);

  state_t              r_state;
  logic                r_ready;
  logic                r_resp_valid;
  logic                r_err;
  logic                r_we;
  logic [1:0]          r_wctr;
  logic [2:0]          r_octr;
  logic [1:0]          r_lane;
  logic [ADDR_W-1:0]   r_widx;
  logic [31:0]         r_wdata;

  logic                w_accept;
  logic                w_err_in;
  logic                w_ram_en;
  logic                w_ram_we;
  logic [31:0]         w_ram_rdata;
  logic [31:0]         w_ram_wdata;
  logic [31:0]         w_new_lanes;
  logic [31:0]         w_merged;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;

  assign w_accept = bus.req_valid && r_ready;

  // Request legality: alignment, address range and control-code validity
  always_comb begin
    w_err_in = 1'b0;
    if (bus.req_addr[31:ADDR_W+2] != '0) w_err_in = 1'b1;
    if (bus.req_we) begin
      case (bus.req_wctr)
        WCTR_WORD: if (bus.req_addr[1:0] != 2'b00) w_err_in = 1'b1;
        WCTR_HALF: if (bus.req_addr[0]) w_err_in = 1'b1;
        WCTR_BYTE: ;
        default:   w_err_in = 1'b1;
      endcase
    end else begin
      case (bus.req_octr)
        OCTR_LW:           if (bus.req_addr[1:0] != 2'b00) w_err_in = 1'b1;
        OCTR_LH, OCTR_LHU: if (bus.req_addr[0]) w_err_in = 1'b1;
        OCTR_LB, OCTR_LBU: ;
        default:           w_err_in = 1'b1;
      endcase
    end
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_wctr       <= WCTR_WORD;
      r_octr       <= OCTR_LW;
      r_lane       <= 2'b00;
      r_widx       <= '0;
      r_wdata      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_err   <= w_err_in;
            r_we    <= bus.req_we;
            r_wctr  <= bus.req_wctr;
            r_octr  <= bus.req_octr;
            r_lane  <= bus.req_addr[1:0];
            r_widx  <= bus.req_addr[ADDR_W+1:2];
            r_wdata <= bus.req_wdata;
            if (w_err_in) begin
              r_state      <= ST_DONE;
              r_resp_valid <= 1'b1;
            end else if (bus.req_we && bus.req_wctr == WCTR_WORD) begin
              r_state <= ST_WRITE;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          r_state      <= ST_DONE;
          r_resp_valid <= 1'b1;
        end
        ST_READ: begin
          if (r_we) begin
            r_state <= ST_MERGE;
          end else begin
            r_state      <= ST_DONE;
            r_resp_valid <= 1'b1;
          end
        end
        ST_MERGE: begin
          r_state      <= ST_DONE;
          r_resp_valid <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Sub-word store data replicated across every lane it could land in
  assign w_new_lanes = (r_wctr == WCTR_BYTE) ? {4{r_wdata[7:0]}} : {2{r_wdata[15:0]}};

  // Per-byte merge: targeted lane(s) take new data, the rest keep the RAM word
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic w_lane_en;
    assign w_lane_en = (r_wctr == WCTR_BYTE) ? (r_lane == 2'(gi))
                                             : (r_lane[1] == 1'(gi / 2));
    assign w_merged[8*gi +: 8] = w_lane_en ? w_new_lanes[8*gi +: 8]
                                           : w_ram_rdata[8*gi +: 8];
  end

  assign w_ram_en    = (r_state == ST_READ) || (r_state == ST_WRITE) || (r_state == ST_MERGE);
  assign w_ram_we    = (r_state == ST_WRITE) || (r_state == ST_MERGE);
  assign w_ram_wdata = (r_state == ST_WRITE) ? r_wdata : w_merged;

  dm_sram #(.ADDR_W(ADDR_W)) u_sram (
    .i_clk   (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (r_widx),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign w_byte = w_ram_rdata[8*r_lane +: 8];
  assign w_half = w_ram_rdata[16*r_lane[1] +: 16];

  // Load lane selection and sign/zero extension from the RAM output word
  always_comb begin
    w_load = '0;
    case (r_octr)
      OCTR_LW:  w_load = w_ram_rdata;
      OCTR_LH:  w_load = {{16{w_half[15]}}, w_half};
      OCTR_LHU: w_load = {16'h0000, w_half};
      OCTR_LB:  w_load = {{24{w_byte[7]}}, w_byte};
      OCTR_LBU: w_load = {24'h000000, w_byte};
      default:  w_load = '0;
    endcase
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_valid && r_err;
  assign bus.resp_rdata = (r_resp_valid && !r_we && !r_err) ? w_load : 32'h0;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed vector table, byte-addressed reference
// model with random traffic, back-to-back requests, and reset mid-operation.
module tb_dm_access_unit;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 10;
  localparam int NBYTES = 4 << ADDR_W;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  dm_access_unit_if bus();

  dm_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference memory kept as individual bytes
  logic [7:0] mem_b [0:NBYTES-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: legality, latency, memory effect and load result
  task automatic ref_access(input logic we, input logic [1:0] wctr, input logic [2:0] octr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic err, output int lat, output logic [31:0] rd);
    int   size;
    logic sgn;
    err = 1'b0; rd = '0; size = 1; sgn = 1'b0;
    if (we) begin
      case (wctr)
        2'b00: size = 4;
        2'b01: size = 2;
        2'b10: size = 1;
        default: err = 1'b1;
      endcase
    end else begin
      case (octr)
        3'b000: begin size = 4; sgn = 1'b0; end
        3'b001: begin size = 2; sgn = 1'b1; end
        3'b010: begin size = 1; sgn = 1'b1; end
        3'b110: begin size = 1; sgn = 1'b0; end
        3'b100: begin size = 2; sgn = 1'b0; end
        default: err = 1'b1;
      endcase
    end
    if ((addr % size) != 0) err = 1'b1;
    if (addr >= NBYTES) err = 1'b1;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++) mem_b[addr + i] = wdata[8*i +: 8];
      lat = (size == 4) ? 2 : 3;
    end else begin
      lat = 2;
      for (int i = 0; i < size; i++) rd[8*i +: 8] = mem_b[addr + i];
      if (sgn && size == 1) rd = 32'($signed(rd[7:0]));
      if (sgn && size == 2) rd = 32'($signed(rd[15:0]));
    end
  endtask

  // Issue one request and wait for its response; lat=99 flags a timeout
  task automatic do_req(input logic we, input logic [1:0] wctr, input logic [2:0] octr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rd, output logic err);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_wctr  = wctr;
    bus.req_octr  = octr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int k = 0; k < 20 && !bus.req_ready; k++) @(negedge clk);
    check("ready_before_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = bus.resp_rdata;
    err = bus.resp_err;
    if (!bus.resp_valid) lat = 99;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  wctr;
    logic [2:0]  octr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  vec_t tv[16];

  initial begin
    int          lat, e_lat, nresp, nacc, cyc, lat_c, e_lat_c;
    logic [31:0] rd, e_rd, e_rd_c;
    logic        err, e_err, e_err_c, outstanding, ready_pre;
    logic        r_we;
    logic [1:0]  r_wctr;
    logic [2:0]  r_octr;
    logic [31:0] r_addr, r_wdata;

    tv[0]  = '{"SW 0x10",        1'b1, WCTR_WORD, OCTR_LW,  32'h10,   32'hDEADBEEF, 1'b0, 2, 32'h0};
    tv[1]  = '{"LW 0x10",        1'b0, WCTR_WORD, OCTR_LW,  32'h10,   32'h0,        1'b0, 2, 32'hDEADBEEF};
    tv[2]  = '{"SB 0x11",        1'b1, WCTR_BYTE, OCTR_LW,  32'h11,   32'h000000A5, 1'b0, 3, 32'h0};
    tv[3]  = '{"LW after SB",    1'b0, WCTR_WORD, OCTR_LW,  32'h10,   32'h0,        1'b0, 2, 32'hDEADA5EF};
    tv[4]  = '{"LB 0x11",        1'b0, WCTR_WORD, OCTR_LB,  32'h11,   32'h0,        1'b0, 2, 32'hFFFFFFA5};
    tv[5]  = '{"LBU 0x11",       1'b0, WCTR_WORD, OCTR_LBU, 32'h11,   32'h0,        1'b0, 2, 32'h000000A5};
    tv[6]  = '{"SH 0x12",        1'b1, WCTR_HALF, OCTR_LW,  32'h12,   32'h00008001, 1'b0, 3, 32'h0};
    tv[7]  = '{"LH 0x12",        1'b0, WCTR_WORD, OCTR_LH,  32'h12,   32'h0,        1'b0, 2, 32'hFFFF8001};
    tv[8]  = '{"LHU 0x12",       1'b0, WCTR_WORD, OCTR_LHU, 32'h12,   32'h0,        1'b0, 2, 32'h00008001};
    tv[9]  = '{"LW after SH",    1'b0, WCTR_WORD, OCTR_LW,  32'h10,   32'h0,        1'b0, 2, 32'h8001A5EF};
    tv[10] = '{"LW 0x13 misal",  1'b0, WCTR_WORD, OCTR_LW,  32'h13,   32'h0,        1'b1, 1, 32'h0};
    tv[11] = '{"SH 0x11 misal",  1'b1, WCTR_HALF, OCTR_LW,  32'h11,   32'h00001234, 1'b1, 1, 32'h0};
    tv[12] = '{"LW after badSH", 1'b0, WCTR_WORD, OCTR_LW,  32'h10,   32'h0,        1'b0, 2, 32'h8001A5EF};
    tv[13] = '{"octr 011",       1'b0, WCTR_WORD, 3'b011,   32'h10,   32'h0,        1'b1, 1, 32'h0};
    tv[14] = '{"addr range",     1'b0, WCTR_WORD, OCTR_LW,  32'h1000, 32'h0,        1'b1, 1, 32'h0};
    tv[15] = '{"wctr 11",        1'b1, 2'b11,     OCTR_LW,  32'h10,   32'h0,        1'b1, 1, 32'h0};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_wctr  = '0;
    bus.req_octr  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready",  32'(bus.req_ready),  32'd1);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_rdata", bus.resp_rdata,      32'd0);
    check("reset resp_err",   32'(bus.resp_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed expectations
    for (int i = 0; i < 16; i++) begin
      ref_access(tv[i].we, tv[i].wctr, tv[i].octr, tv[i].addr, tv[i].wdata, e_err, e_lat, e_rd);
      do_req(tv[i].we, tv[i].wctr, tv[i].octr, tv[i].addr, tv[i].wdata, lat, rd, err);
      check({tv[i].name, " lat"},   32'(lat), 32'(tv[i].lat));
      check({tv[i].name, " err"},   32'(err), 32'(tv[i].err));
      check({tv[i].name, " rdata"}, rd,       tv[i].rd);
      $display("vec %0d %s: lat=%0d err=%0d rdata=%h", i, tv[i].name, lat, err, rd);
      @(posedge clk); #1;
      check({tv[i].name, " pulse"}, 32'(bus.resp_valid), 32'd0);
    end

    // Initialise the random region 0x100..0x13F with word stores
    for (int w = 0; w < 16; w++) begin
      r_wdata = $urandom;
      ref_access(1'b1, WCTR_WORD, OCTR_LW, 32'h100 + 32'(4 * w), r_wdata, e_err, e_lat, e_rd);
      do_req(1'b1, WCTR_WORD, OCTR_LW, 32'h100 + 32'(4 * w), r_wdata, lat, rd, err);
      check("init lat", 32'(lat), 32'(e_lat));
    end

    // Random mix of loads, stores and illegal requests
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind    = $urandom_range(0, 9);
      r_addr  = 32'h100 + 32'($urandom_range(0, 63));
      r_wdata = $urandom;
      r_we    = (kind <= 2);
      r_wctr  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0: r_octr = 3'b000;
        1: r_octr = 3'b001;
        2: r_octr = 3'b010;
        3: r_octr = 3'b110;
        4: r_octr = 3'b100;
        default: r_octr = 3'($urandom_range(0, 7));
      endcase
      if (kind == 9) r_addr = r_addr | (32'h1 << $urandom_range(ADDR_W + 2, 31));
      ref_access(r_we, r_wctr, r_octr, r_addr, r_wdata, e_err, e_lat, e_rd);
      do_req(r_we, r_wctr, r_octr, r_addr, r_wdata, lat, rd, err);
      check("rand lat",   32'(lat), 32'(e_lat));
      check("rand err",   32'(err), 32'(e_err));
      check("rand rdata", rd,       e_rd);
      $display("rand %0d we=%0d wctr=%0d octr=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h",
               n, r_we, r_wctr, r_octr, r_addr, r_wdata, lat, err, rd);
    end

    // req_valid held high: alternating SB / LW, one response per acceptance
    @(posedge clk); #1;
    nacc = 0; nresp = 0; outstanding = 1'b0; lat_c = 0;
    e_err_c = 1'b0; e_lat_c = 0; e_rd_c = '0;
    r_we = 1'b1; r_wctr = WCTR_BYTE; r_octr = OCTR_LW;
    r_addr = 32'h100 + 32'($urandom_range(0, 63)); r_wdata = $urandom;
    bus.req_valid = 1'b1;
    bus.req_we = r_we; bus.req_wctr = r_wctr; bus.req_octr = r_octr;
    bus.req_addr = r_addr; bus.req_wdata = r_wdata;
    for (cyc = 0; cyc < 400 && nresp < 20; cyc++) begin
      @(negedge clk);
      ready_pre = bus.req_ready;
      @(posedge clk); #1;
      if (ready_pre && bus.req_valid) begin
        check("b2b accept while busy", 32'(outstanding), 32'd0);
        ref_access(r_we, r_wctr, r_octr, r_addr, r_wdata, e_err_c, e_lat_c, e_rd_c);
        outstanding = 1'b1;
        lat_c = 1;
        nacc++;
        if (nacc < 20) begin
          r_we = (nacc % 2 == 0);
          r_wctr = WCTR_BYTE;
          r_octr = OCTR_LW;
          r_addr = r_we ? 32'h100 + 32'($urandom_range(0, 63))
                        : 32'h100 + 32'(4 * $urandom_range(0, 15));
          r_wdata = $urandom;
          bus.req_we = r_we; bus.req_wctr = r_wctr; bus.req_octr = r_octr;
          bus.req_addr = r_addr; bus.req_wdata = r_wdata;
        end else begin
          bus.req_valid = 1'b0;
        end
      end else if (outstanding) begin
        lat_c++;
      end
      if (outstanding) check("b2b ready while busy", 32'(bus.req_ready), 32'd0);
      if (bus.resp_valid) begin
        check("b2b response expected", 32'(outstanding), 32'd1);
        check("b2b lat",   32'(lat_c), 32'(e_lat_c));
        check("b2b err",   32'(bus.resp_err), 32'(e_err_c));
        check("b2b rdata", bus.resp_rdata, e_rd_c);
        $display("b2b resp %0d: lat=%0d rdata=%h", nresp, lat_c, bus.resp_rdata);
        outstanding = 1'b0;
        nresp++;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b accepted count", 32'(nacc),  32'd20);
    check("b2b response count", 32'(nresp), 32'd20);
    repeat (3) @(posedge clk);
    #1;
    check("b2b no extra response", 32'(bus.resp_valid), 32'd0);

    // Reset asserted while an SB sits in READ: the store must be dropped
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1; bus.req_wctr = WCTR_BYTE; bus.req_octr = OCTR_LW;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h11;
    for (int k = 0; k < 20 && !bus.req_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midreset req_ready",  32'(bus.req_ready),  32'd1);
    check("midreset resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midreset hold resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midreset hold req_ready",  32'(bus.req_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ref_access(1'b0, WCTR_WORD, OCTR_LW, 32'h10, 32'h0, e_err, e_lat, e_rd);
    do_req(1'b0, WCTR_WORD, OCTR_LW, 32'h10, 32'h0, lat, rd, err);
    check("post-reset LW lat",   32'(lat), 32'd2);
    check("post-reset LW rdata", rd, 32'h8001A5EF);
    check("post-reset LW model", rd, e_rd);
    $display("post-reset LW 0x10: lat=%0d rdata=%h", lat, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
